trace_mem_ctrl: RTL and testbench

TRACE_MEM_CTRL -- requirements
Module: trace_mem_ctrl

---
 rtl/dtb_pkg.sv | 13 +
 rtl/trace_mem_ctrl_trig.sv | 49 ++++
 rtl/trb_sp_ram.sv | 20 ++
 rtl/trace_mem_ctrl.sv | 113 +++++++++++
 tb/tb_trace_mem_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtb_pkg.sv
// Shared sizing for the trace buffer controller and its external RAM.
// Depth must stay a power of two so the pointers wrap for free.
package dtb_pkg;
    localparam int TRB_DEPTH      = 8;
    localparam int TRB_ADDR_BITS  = $clog2(TRB_DEPTH);
    localparam int TRB_DELAY_BITS = 8;
    localparam int TRB_WIDTH      = 16;

    typedef enum logic {
        MODE_TRACE  = 1'b0,
        MODE_STREAM = 1'b1
    } trb_mode_e;
endpackage

// File: rtl/trace_mem_ctrl_trig.sv
// Trigger capture and post-trigger delay counter; freezes the trace buffer.
module trace_mem_ctrl_trig
    import dtb_pkg::*;
#(
    parameter int DELAY_BITS = TRB_DELAY_BITS
) (
    input  logic                     FPGA_CLK_I,
    input  logic                     RST_I,
    input  logic                     enable,
    input  logic                     trg_event,
    input  logic [DELAY_BITS-1:0]    trg_delay,
    input  logic                     commit,
    input  logic [TRB_ADDR_BITS-1:0] wr_next_addr,
    output logic                     trg_delayed,
    output logic [TRB_ADDR_BITS-1:0] event_addr
);
    logic                  trg_seen;
    logic                  trg_first;
    logic [DELAY_BITS-1:0] cnt;
    logic [DELAY_BITS-1:0] cnt_nxt;

    assign trg_first = enable && trg_event && !trg_seen;

    // A commit in the trigger cycle belongs to the pre-trigger history
    always_comb begin
        cnt_nxt = cnt;
        if (trg_first)
            cnt_nxt = '0;
        else if (trg_seen && commit && !trg_delayed)
            cnt_nxt = cnt + DELAY_BITS'(1);
    end

    always_ff @(posedge FPGA_CLK_I or posedge RST_I) begin
        if (RST_I) begin
            trg_seen    <= 1'b0;
            cnt         <= '0;
            trg_delayed <= 1'b0;
            event_addr  <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (trg_first) begin
                trg_seen   <= 1'b1;
                event_addr <= wr_next_addr;
            end
            if ((trg_first || trg_seen) && cnt_nxt == trg_delay)
                trg_delayed <= 1'b1;
        end
    end
endmodule

// File: rtl/trb_sp_ram.sv
// Behavioural single-port RAM with one cycle of read latency.
module trb_sp_ram
    import dtb_pkg::*;
(
    input  logic                     FPGA_CLK_I,
    input  logic                     EN_I,
    input  logic                     WE_I,
    input  logic [TRB_ADDR_BITS-1:0] ADDR_I,
    input  logic [TRB_WIDTH-1:0]     WDATA_I,
    output logic [TRB_WIDTH-1:0]     RDATA_O
);
    logic [TRB_WIDTH-1:0] mem [TRB_DEPTH];

    always_ff @(posedge FPGA_CLK_I) begin
        if (EN_I) begin
            if (WE_I) mem[ADDR_I] <= WDATA_I;
            else      RDATA_O     <= mem[ADDR_I];
        end
    end
endmodule

// File: rtl/trace_mem_ctrl.sv
// Trace/stream buffer controller: one-deep store buffer, single-port RAM
// arbitration (writes first) and a two-stage read return path.
module trace_mem_ctrl
    import dtb_pkg::*;
#(
    parameter int DELAY_BITS = TRB_DELAY_BITS
) (
    input  logic                     FPGA_CLK_I,
    input  logic                     RST_I,
    input  logic                     MODE_I,
    input  logic                     TRG_EVENT_I,
    input  logic [DELAY_BITS-1:0]    TRG_DELAY_I,
    output logic                     TRG_DELAYED_O,
    output logic [TRB_ADDR_BITS-1:0] EVENT_ADDR_O,
    input  logic                     STORE_I,
    output logic                     STORE_PERM_O,
    input  logic [TRB_WIDTH-1:0]     DATA_I,
    input  logic                     LOAD_REQUEST_I,
    output logic                     LOAD_GRANT_O,
    output logic [TRB_WIDTH-1:0]     DATA_O,
    output logic                     MEM_EN_O,
    output logic                     MEM_WE_O,
    output logic [TRB_ADDR_BITS-1:0] MEM_ADDR_O,
    output logic [TRB_WIDTH-1:0]     MEM_WDATA_O,
    input  logic [TRB_WIDTH-1:0]     MEM_RDATA_I,
    output logic [TRB_ADDR_BITS:0]   FILL_O
);
    localparam int A = TRB_ADDR_BITS;
    localparam logic [A:0]   FULL = (A+1)'(TRB_DEPTH);
    localparam logic [A+2:0] DEPTH_W = (A+3)'(TRB_DEPTH);

    logic                 stream, frozen, capture, commit, rd_issue;
    logic                 buf_vld;
    logic [TRB_WIDTH-1:0] buf_data;
    logic [A-1:0]         wr_ptr, rd_ptr, wr_next_addr;
    logic [A:0]           fill;
    logic [A+2:0]         perm_sum;
    logic                 rd_vld_p1, grant_p2;
    logic [TRB_WIDTH-1:0] data_p2;
    logic                 trg_delayed;

    assign stream   = (trb_mode_e'(MODE_I) == MODE_STREAM);
    assign frozen   = !stream && trg_delayed;
    assign capture  = STORE_I && !frozen;
    assign commit   = buf_vld && !frozen;
    assign rd_issue = !RST_I && LOAD_REQUEST_I && !rd_vld_p1 && !commit
                      && (!stream || fill != '0);

    assign wr_next_addr = wr_ptr + A'(buf_vld);
    assign perm_sum     = (A+3)'(fill) + (A+3)'(buf_vld) + (A+3)'(STORE_I);
    assign STORE_PERM_O = RST_I || (stream ? (perm_sum < DEPTH_W) : !trg_delayed);

    assign MEM_EN_O      = commit || rd_issue;
    assign MEM_WE_O      = commit;
    assign MEM_ADDR_O    = commit ? wr_ptr : rd_ptr;
    assign MEM_WDATA_O   = buf_data;
    assign FILL_O        = fill;
    assign LOAD_GRANT_O  = grant_p2;
    assign DATA_O        = data_p2;
    assign TRG_DELAYED_O = trg_delayed;

    always_ff @(posedge FPGA_CLK_I or posedge RST_I) begin
        if (RST_I) begin
            buf_vld  <= 1'b0;
            buf_data <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
        end else begin
            if (capture) begin
                buf_vld  <= 1'b1;
                buf_data <= DATA_I;
            end else if (commit || frozen) begin
                buf_vld  <= 1'b0;
            end
            if (commit) wr_ptr <= wr_ptr + A'(1);
            // Once the ring is full each write evicts the oldest word
            if (rd_issue)
                rd_ptr <= rd_ptr + A'(1);
            else if (commit && !stream && fill == FULL)
                rd_ptr <= wr_ptr + A'(1);
            if (commit && fill != FULL)
                fill <= fill + (A+1)'(1);
            else if (rd_issue && fill != '0)
                fill <= fill - (A+1)'(1);
        end
    end

    // Read return: RAM data valid in stage 1, registered out with grant in stage 2
    always_ff @(posedge FPGA_CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rd_vld_p1 <= 1'b0;
            grant_p2  <= 1'b0;
            data_p2   <= '0;
        end else begin
            rd_vld_p1 <= rd_issue;
            grant_p2  <= rd_vld_p1;
            if (rd_vld_p1) data_p2 <= MEM_RDATA_I;
        end
    end

    trace_mem_ctrl_trig #(.DELAY_BITS(DELAY_BITS)) u_trig (
        .FPGA_CLK_I   (FPGA_CLK_I),
        .RST_I        (RST_I),
        .enable       (!stream),
        .trg_event    (TRG_EVENT_I),
        .trg_delay    (TRG_DELAY_I),
        .commit       (commit),
        .wr_next_addr (wr_next_addr),
        .trg_delayed  (trg_delayed),
        .event_addr   (EVENT_ADDR_O)
    );
endmodule

// File: tb/tb_trace_mem_ctrl.sv
// Scenario bench for trace_mem_ctrl with a behavioural RAM and a word scoreboard.
module tb_trace_mem_ctrl;
    import dtb_pkg::*;
    localparam int W = TRB_WIDTH;
    localparam int A = TRB_ADDR_BITS;
    localparam int D = TRB_DELAY_BITS;

    logic         clk = 1'b0;
    logic         rst, mode, trg_ev, store, load_req;
    logic [D-1:0] trg_delay;
    logic [W-1:0] din;
    logic         trg_delayed, perm, grant, mem_en, mem_we;
    logic [A-1:0] event_addr, mem_addr;
    logic [W-1:0] dout, mem_wdata, mem_rdata;
    logic [A:0]   fill;

    int total = 0;
    int passed = 0;
    logic [W-1:0] sb [$];

    always #5 clk = ~clk;

    trace_mem_ctrl #(.DELAY_BITS(D)) dut (
        .FPGA_CLK_I(clk), .RST_I(rst), .MODE_I(mode),
        .TRG_EVENT_I(trg_ev), .TRG_DELAY_I(trg_delay), .TRG_DELAYED_O(trg_delayed),
        .EVENT_ADDR_O(event_addr), .STORE_I(store), .STORE_PERM_O(perm),
        .DATA_I(din), .LOAD_REQUEST_I(load_req), .LOAD_GRANT_O(grant),
        .DATA_O(dout), .MEM_EN_O(mem_en), .MEM_WE_O(mem_we),
        .MEM_ADDR_O(mem_addr), .MEM_WDATA_O(mem_wdata), .MEM_RDATA_I(mem_rdata),
        .FILL_O(fill)
    );

    trb_sp_ram u_ram (
        .FPGA_CLK_I(clk), .EN_I(mem_en), .WE_I(mem_we), .ADDR_I(mem_addr),
        .WDATA_I(mem_wdata), .RDATA_O(mem_rdata)
    );

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic m);
        rst = 1'b1; mode = m; trg_ev = 1'b0; trg_delay = '0;
        store = 1'b0; din = '0; load_req = 1'b0;
        sb.delete();
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic do_store(input logic [W-1:0] d, input bit push);
        store = 1'b1; din = d;
        if (push) sb.push_back(d);
        cyc();
        store = 1'b0;
    endtask

    // Request raised in a cycle where the read is expected to issue at once
    task automatic load_one(input string name);
        int lat;
        load_req = 1'b1; #1;
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0)
            $display("FAIL %s issue: en=%b we=%b required en=1 we=0", name, mem_en, mem_we);
        else passed++;
        cyc();
        load_req = 1'b0;
        lat = 1;
        while (grant !== 1'b1 && lat < 6) begin cyc(); lat++; end
        total++;
        if (lat !== 2) $display("FAIL %s latency: got %0d required 2", name, lat);
        else passed++;
        total++;
        if (sb.size() == 0) $display("FAIL %s scoreboard: got empty required word", name);
        else begin
            logic [W-1:0] exp;
            exp = sb.pop_front();
            if (dout !== exp) $display("FAIL %s data: got %h required %h", name, dout, exp);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; load_req = 1'b1; store = 1'b0;
        trg_ev = 1'b0; trg_delay = '0; din = '0;
        cyc(); cyc();
        total++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL reset_mem: en=%b we=%b required 0 0", mem_en, mem_we);
        else passed++;
        total++;
        if (perm !== 1'b1) $display("FAIL reset_perm: got %b required 1", perm);
        else passed++;
        total++;
        if (fill !== '0 || grant !== 1'b0 || dout !== '0)
            $display("FAIL reset_state: fill=%0d grant=%b data=%h required 0 0 0", fill, grant, dout);
        else passed++;
        total++;
        if (trg_delayed !== 1'b0 || event_addr !== '0)
            $display("FAIL reset_trig: delayed=%b addr=%0d required 0 0", trg_delayed, event_addr);
        else passed++;
        load_req = 1'b0;
        rst = 1'b0;
        cyc();
        total++;
        if (perm !== 1'b1) $display("FAIL reset_perm_after: got %b required 1", perm);
        else passed++;
    endtask

    task automatic test_stream_fill();
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) do_store(W'(16'hA0 + i), 1'b1);
        cyc();
        total++;
        if (fill !== (A+1)'(8)) $display("FAIL stream_fill: got %0d required 8", fill);
        else passed++;
        total++;
        if (perm !== 1'b0) $display("FAIL stream_full_perm: got %b required 0", perm);
        else passed++;
        load_one("stream_first");
        total++;
        if (perm !== 1'b1 || fill !== (A+1)'(7))
            $display("FAIL stream_after_load: perm=%b fill=%0d required 1 7", perm, fill);
        else passed++;
        for (int i = 0; i < 3; i++) load_one("stream_drain");
    endtask

    task automatic test_store_load_same();
        int lat;
        do_store(W'(16'hB0), 1'b1);
        load_req = 1'b1; #1;
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1)
            $display("FAIL same_write_first: en=%b we=%b required 1 1", mem_en, mem_we);
        else passed++;
        cyc();
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0)
            $display("FAIL same_read_next: en=%b we=%b required 1 0", mem_en, mem_we);
        else passed++;
        cyc();
        load_req = 1'b0;
        lat = 2;
        while (grant !== 1'b1 && lat < 8) begin cyc(); lat++; end
        total++;
        if (lat !== 3) $display("FAIL same_grant_latency: got %0d required 3", lat);
        else passed++;
        total++;
        if (dout !== sb[0]) $display("FAIL same_data: got %h required %h", dout, sb[0]);
        else passed++;
        void'(sb.pop_front());
    endtask

    task automatic test_stream_empty();
        bit early;
        do_reset(1'b1);
        load_req = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 3; i++) begin #1; if (mem_en !== 1'b0) early = 1'b1; cyc(); end
        store = 1'b1; din = 16'h55; sb.push_back(16'h55); #1;
        if (mem_en !== 1'b0) early = 1'b1;
        total++;
        if (early) $display("FAIL empty_no_read: got mem_en=1 required 0");
        else passed++;
        cyc();
        store = 1'b0; #1;
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1)
            $display("FAIL empty_commit: en=%b we=%b required 1 1", mem_en, mem_we);
        else passed++;
        cyc();
        load_one("empty_first_word");
    endtask

    task automatic test_trace_delay3();
        do_reset(1'b0);
        trg_delay = D'(3);
        for (int i = 0; i < 5; i++) do_store(W'(16'hC0 + i), 1'b1);
        cyc();
        trg_ev = 1'b1;
        cyc();
        total++;
        if (event_addr !== A'(5)) $display("FAIL trace_event_addr: got %0d required 5", event_addr);
        else passed++;
        for (int i = 5; i < 8; i++) do_store(W'(16'hC0 + i), 1'b1);
        total++;
        if (trg_delayed !== 1'b0 || perm !== 1'b1)
            $display("FAIL trace_pre_delay: delayed=%b perm=%b required 0 1", trg_delayed, perm);
        else passed++;
        cyc();
        total++;
        if (trg_delayed !== 1'b1 || perm !== 1'b0)
            $display("FAIL trace_delayed: delayed=%b perm=%b required 1 0", trg_delayed, perm);
        else passed++;
        do_store(W'(16'hEE), 1'b0);
        #1;
        total++;
        if (mem_en !== 1'b0 || fill !== (A+1)'(8))
            $display("FAIL trace_frozen_store: en=%b fill=%0d required 0 8", mem_en, fill);
        else passed++;
        cyc();
        for (int i = 0; i < 8; i++) load_one("trace_readback");
    endtask

    task automatic test_trace_delay0_wrap();
        do_reset(1'b0);
        trg_delay = '0;
        for (int i = 0; i < 10; i++) do_store(W'(16'hD0 + i), 1'b1);
        void'(sb.pop_front());
        void'(sb.pop_front());
        cyc();
        trg_ev = 1'b1; #1;
        total++;
        if (trg_delayed !== 1'b0) $display("FAIL d0_trigger_cycle: got %b required 0", trg_delayed);
        else passed++;
        cyc();
        total++;
        if (trg_delayed !== 1'b1 || event_addr !== A'(2))
            $display("FAIL d0_delayed: delayed=%b addr=%0d required 1 2", trg_delayed, event_addr);
        else passed++;
        do_store(W'(16'hEE), 1'b0);
        #1;
        total++;
        if (mem_en !== 1'b0 || fill !== (A+1)'(8))
            $display("FAIL d0_zero_writes: en=%b fill=%0d required 0 8", mem_en, fill);
        else passed++;
        cyc();
        for (int i = 0; i < 8; i++) load_one("wrap_oldest");
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        do_reset(1'b1);
        do_store(W'(16'h77), 1'b0);
        cyc();
        load_req = 1'b1;
        cyc();
        rst = 1'b1; load_req = 1'b0; #1;
        total++;
        if (fill !== '0 || grant !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 || dout !== '0 || perm !== 1'b1)
            $display("FAIL midread_reset: fill=%0d grant=%b en=%b we=%b data=%h perm=%b required 0 0 0 0 0 1",
                     fill, grant, mem_en, mem_we, dout, perm);
        else passed++;
        cyc(); cyc();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin cyc(); if (grant !== 1'b0) seen = 1'b1; end
        total++;
        if (seen) $display("FAIL midread_no_grant: got grant=1 required 0");
        else passed++;
        total++;
        if (dout !== '0) $display("FAIL midread_data: got %h required 0", dout);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream_fill();
        test_store_load_same();
        test_stream_empty();
        test_trace_delay3();
        test_trace_delay0_wrap();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
